// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Single-outstanding request controller between a processor-side
//   valid/ready port and a simple synchronous-write / combinational-read
//   main memory. Each request passes through IDLE -> ACCESS -> RESP.
//   A request whose address is outside the implemented depth skips
//   ACCESS and is answered straight away with rsp_err set.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_write                  1 = store, 0 = load
//   req_addr, req_wdata        word address and store data
//   rsp_valid / rsp_ready      response handshake (valid only in RESP)
//   rsp_rdata                  load data (0 for stores and errors)
//   rsp_err                    address out of range
//   mem_write                  one-cycle write strobe to main memory
//   mem_address, mem_in_data   registered request address / data
//   mem_out_data               combinational read data from main memory

module mem_access_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in_data,
    input  logic [DATA_W-1:0] mem_out_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t              state;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                in_range;

    // Unsigned, full-width compare: every code from DEPTH upward is an error.
    assign in_range = (32'(req_addr) < DEPTH_U);

    assign mem_address = addr_q;
    assign mem_in_data = wdata_q;

    // Handshake outputs and the write strobe are flops updated on the same
    // edge as the state, so each one mirrors its state exactly and the
    // asynchronous reset clears them without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (in_range) begin
                            state     <= ACCESS;
                            mem_write <= req_write;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    mem_write <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= wr_q ? '0 : mem_out_data;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_write <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_write;
    logic [4:0]  mem_address;
    logic [15:0] mem_in_data;
    logic [15:0] mem_out_data;

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(5), .DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_in_data  (mem_in_data),
        .mem_out_data (mem_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory model: written by the DUT strobe or by bench preloads.
    logic [15:0] mem [0:31];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    int unsigned wr_cnt = 0;
    logic [4:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    int unsigned cyc = 0;

    assign mem_out_data = mem[mem_address];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) begin
            mem[mem_address] <= mem_in_data;
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_address;
            wr_data <= mem_in_data;
        end else if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end
    end

    // Reference memory contents and the response scoreboard.
    logic [15:0] ref_mem [0:31];

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [4:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Drive one request from a negedge, wait (bounded) for acceptance and
    // push the expected response. Returns at the negedge after acceptance.
    task automatic issue(input logic w, input logic [4:0] a, input logic [15:0] d,
                         output bit ok);
        exp_t e;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            e.err   = (a >= 5'd16);
            e.lat   = e.err ? 1 : 2;
            e.rdata = (e.err || w) ? 16'h0000 : ref_mem[a];
            if (!e.err && w) ref_mem[a] = d;
            e.acc   = cyc;
            sb.push_back(e);
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, sample it, pop its expectation and let
    // it retire (rsp_ready must be 1). Returns at a negedge.
    task automatic get_rsp(output bit got, output logic [15:0] rd, output logic er,
                           output int unsigned lat, output exp_t e);
        got = 1'b0; rd = '0; er = 1'b0; lat = 0;
        e.rdata = '0; e.err = 1'b0; e.lat = 0; e.acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (got && sb.size() > 0) begin
            rd  = rsp_rdata;
            er  = rsp_err;
            e   = sb.pop_front();
            lat = cyc - e.acc;
            @(negedge clk);
        end else begin
            got = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b1;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (mem_write !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
        n_cmp++; if (mem_address !== 5'd0)  begin n_fail++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
        n_cmp++; if (mem_in_data !== 16'd0) begin n_fail++; $display("FAIL reset_mem_in_data: got %h expected 0", mem_in_data); end
        n_cmp++; if (rsp_rdata !== 16'd0)   begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0)      begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        bit ok, got; logic [15:0] rd; logic er; int unsigned lat; exp_t e; int unsigned w0;
        preload(5'd11, 16'd20);
        w0 = wr_cnt;
        issue(1'b0, 5'd11, 16'h0000, ok);
        get_rsp(got, rd, er, lat, e);
        n_cmp++; if (!(ok && got))   begin n_fail++; $display("FAIL load_handshake: got accepted=%b responded=%b expected 1/1", ok, got); end
        n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL load_rdata: got %h expected %h", rd, e.rdata); end
        n_cmp++; if (er !== e.err)   begin n_fail++; $display("FAIL load_err: got %b expected %b", er, e.err); end
        n_cmp++; if (lat !== e.lat)  begin n_fail++; $display("FAIL load_latency: got %0d expected %0d", lat, e.lat); end
        n_cmp++; if (wr_cnt !== w0)  begin n_fail++; $display("FAIL load_no_write: got %0d strobes expected 0", wr_cnt - w0); end
    endtask

    task automatic test_store_load();
        bit ok, got; logic [15:0] rd; logic er; int unsigned lat; exp_t e; int unsigned w0;
        w0 = wr_cnt;
        issue(1'b1, 5'd3, 16'hBEEF, ok);
        get_rsp(got, rd, er, lat, e);
        n_cmp++; if (!(ok && got))        begin n_fail++; $display("FAIL store_handshake: got accepted=%b responded=%b expected 1/1", ok, got); end
        n_cmp++; if (wr_cnt - w0 !== 1)   begin n_fail++; $display("FAIL store_strobe_count: got %0d expected 1", wr_cnt - w0); end
        n_cmp++; if (wr_addr !== 5'd3)    begin n_fail++; $display("FAIL store_addr: got %h expected 3", wr_addr); end
        n_cmp++; if (wr_data !== 16'hBEEF) begin n_fail++; $display("FAIL store_data: got %h expected beef", wr_data); end
        n_cmp++; if (rd !== e.rdata)      begin n_fail++; $display("FAIL store_rdata: got %h expected %h", rd, e.rdata); end
        n_cmp++; if (lat !== e.lat)       begin n_fail++; $display("FAIL store_latency: got %0d expected %0d", lat, e.lat); end
        issue(1'b0, 5'd3, 16'h0000, ok);
        get_rsp(got, rd, er, lat, e);
        n_cmp++; if (!(ok && got))   begin n_fail++; $display("FAIL reload_handshake: got accepted=%b responded=%b expected 1/1", ok, got); end
        n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL reload_rdata: got %h expected %h", rd, e.rdata); end
        n_cmp++; if (er !== e.err)   begin n_fail++; $display("FAIL reload_err: got %b expected %b", er, e.err); end
    endtask

    task automatic test_out_of_range();
        bit ok, got; logic [15:0] rd; logic er; int unsigned lat; exp_t e; int unsigned w0;
        logic [4:0] addrs [2];
        addrs[0] = 5'd16; addrs[1] = 5'd31;
        for (int k = 0; k < 2; k++) begin
            w0 = wr_cnt;
            issue(1'b1, addrs[k], 16'h1111, ok);
            get_rsp(got, rd, er, lat, e);
            n_cmp++; if (!(ok && got))   begin n_fail++; $display("FAIL oor_handshake[%0d]: got accepted=%b responded=%b expected 1/1", addrs[k], ok, got); end
            n_cmp++; if (er !== e.err)   begin n_fail++; $display("FAIL oor_err[%0d]: got %b expected %b", addrs[k], er, e.err); end
            n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL oor_rdata[%0d]: got %h expected %h", addrs[k], rd, e.rdata); end
            n_cmp++; if (lat !== e.lat)  begin n_fail++; $display("FAIL oor_latency[%0d]: got %0d expected %0d", addrs[k], lat, e.lat); end
            n_cmp++; if (wr_cnt !== w0)  begin n_fail++; $display("FAIL oor_no_write[%0d]: got %0d strobes expected 0", addrs[k], wr_cnt - w0); end
        end
    endtask

    task automatic test_backpressure();
        bit ok, got; exp_t e; int unsigned w0;
        preload(5'd12, 16'h1234);
        rsp_ready = 1'b0;
        issue(1'b0, 5'd12, 16'h0000, ok);
        w0 = wr_cnt;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (!(ok && got && sb.size() == 1)) begin n_fail++; $display("FAIL bp_handshake: got accepted=%b responded=%b expected 1/1", ok, got); end
        e = (sb.size() > 0) ? sb[0] : '{16'h0, 1'b0, 0, 0};
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd7; req_wdata = 16'hFFFF;
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 1'b1)   begin n_fail++; $display("FAIL bp_rsp_valid[%0d]: got %b expected 1", c, rsp_valid); end
            n_cmp++; if (rsp_rdata !== e.rdata) begin n_fail++; $display("FAIL bp_rsp_rdata[%0d]: got %h expected %h", c, rsp_rdata, e.rdata); end
            n_cmp++; if (req_ready !== 1'b0)   begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", c, req_ready); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        if (sb.size() > 0) void'(sb.pop_front());
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_retire_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_retire_ready: got %b expected 1", req_ready); end
        n_cmp++; if (wr_cnt !== w0)      begin n_fail++; $display("FAIL bp_ignored_req: got %0d strobes expected 0", wr_cnt - w0); end
    endtask

    task automatic test_reset_mid_store();
        bit ok, got; logic [15:0] rd; logic er; int unsigned lat; exp_t e; int unsigned w0;
        int seen;
        preload(5'd5, 16'h5555);
        issue(1'b1, 5'd5, 16'hAAAA, ok);
        ref_mem[5] = 16'h5555;
        n_cmp++; if (!(ok && mem_write === 1'b1)) begin n_fail++; $display("FAIL mid_access_strobe: got accepted=%b mem_write=%b expected 1/1", ok, mem_write); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL mid_reset_mem_write: got %b expected 0", mem_write); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_req_ready: got %b expected 1", req_ready); end
        sb.delete();
        w0 = wr_cnt;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        n_cmp++; if (seen !== 0)    begin n_fail++; $display("FAIL mid_reset_no_rsp: got %0d response cycles expected 0", seen); end
        n_cmp++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL mid_reset_no_write: got %0d strobes expected 0", wr_cnt - w0); end
        issue(1'b0, 5'd5, 16'h0000, ok);
        get_rsp(got, rd, er, lat, e);
        n_cmp++; if (!(ok && got) || rd !== e.rdata) begin n_fail++; $display("FAIL mid_reset_mem_intact: got %h expected %h", rd, e.rdata); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  addrs [3];
        int unsigned acc_c [3];
        int          n_acc, n_rsp;
        bit          acc_prev;
        exp_t        e;
        addrs[0] = 5'd11; addrs[1] = 5'd3; addrs[2] = 5'd12;
        n_acc = 0; n_rsp = 0; acc_prev = 1'b0;
        rsp_ready = 1'b1; req_write = 1'b0; req_wdata = '0;
        req_addr = addrs[0]; req_valid = 1'b1;
        for (int c = 0; c < 40 && n_rsp < 3; c++) begin
            if (acc_prev) begin
                if (n_acc < 3) req_addr = addrs[n_acc];
                else req_valid = 1'b0;
            end
            if (rsp_valid && sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++; if (rsp_rdata !== e.rdata) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", n_rsp, rsp_rdata, e.rdata); end
                n_rsp++;
            end
            acc_prev = req_valid && req_ready;
            if (acc_prev) begin
                e.err = 1'b0; e.lat = 2; e.acc = cyc;
                e.rdata = ref_mem[req_addr];
                sb.push_back(e);
                acc_c[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_cmp++; if (n_rsp !== 3) begin n_fail++; $display("FAIL b2b_responses: got %0d expected 3", n_rsp); end
        if (n_acc == 3) begin
            n_cmp++; if (acc_c[1] - acc_c[0] !== 3) begin n_fail++; $display("FAIL b2b_gap01: got %0d expected 3", acc_c[1] - acc_c[0]); end
            n_cmp++; if (acc_c[2] - acc_c[1] !== 3) begin n_fail++; $display("FAIL b2b_gap12: got %0d expected 3", acc_c[2] - acc_c[1]); end
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL b2b_acceptances: got %0d expected 3", n_acc);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_load();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_store();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
